// File: rtl/sccb_responder_pkg.sv
// Shared SCCB definitions: responder state encoding, default device ID and
// the ACK/NA bit values used by both the responder and the setup master.
package sccb_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID,
        ST_SUB,
        ST_WDATA,
        ST_RDATA,
        ST_ACK_W,
        ST_ACK_R,
        ST_IGNORE
    } sccb_state_t;

    localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;
    localparam logic       SCCB_ACK        = 1'b0;
    localparam logic       SCCB_NA         = 1'b1;

    // Bit 0 of the ID byte is the R/W flag and takes no part in the match
    function automatic logic sccb_id_match(input logic [7:0] rx, input logic [7:0] id);
        return ((rx ^ id) & 8'hFE) == 8'h00;
    endfunction

endpackage

// File: rtl/sccb_responder_line_sync.sv
// Two-flop synchronizers for SIOC/SIOD plus SCL edge and START/STOP pulses.
module sccb_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sioc_i,
    input  logic siod_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_q;
    logic       sda_q;
    logic       scl;

    // Idle bus is high; resetting to 1 keeps reset release from looking like an edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scl_ff <= '1;
            sda_ff <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_ff <= {scl_ff[0], sioc_i};
            sda_ff <= {sda_ff[0], siod_i};
            scl_q  <= scl_ff[1];
            sda_q  <= sda_ff[1];
        end
    end

    assign scl       = scl_ff[1];
    assign sda       = sda_ff[1];
    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target emulating an OV7670: decodes 3-phase writes and 2-phase read
// sequences and drives a simple strobe interface to an external register store.
module sccb_responder
    import sccb_responder_pkg::*;
#(
    parameter logic [7:0]  DEV_ID   = SCCB_DEFAULT_ID,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sioc_i,
    inout  wire        siod_io,
    output logic [7:0] addr_o,
    output logic [7:0] wdata_o,
    output logic       wr_o,
    output logic       rd_o,
    input  logic [7:0] rdata_i,
    output logic       busy_o
);

    localparam int unsigned HW = $clog2(HOLD_CYC + 1);

    sccb_state_t state;
    sccb_state_t ack_next;
    logic [3:0]  bit_cnt;
    logic [7:0]  shreg;
    logic [7:0]  rx_byte;
    logic [HW-1:0] hold_cnt;
    logic        drive_low;
    logic        first_wr;
    logic        rd_q;

    logic sda, scl_rise, scl_fall, start_det, stop_det;

    sccb_line_sync u_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sioc_i    (sioc_i),
        .siod_i    (siod_io),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign siod_io = drive_low ? 1'b0 : 1'bz;
    assign rx_byte = {shreg[6:0], sda};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= ST_IDLE;
            ack_next  <= ST_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold_cnt  <= '0;
            drive_low <= 1'b0;
            first_wr  <= 1'b0;
            rd_q      <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            wr_o      <= 1'b0;
            rd_o      <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            wr_o <= 1'b0;
            rd_o <= 1'b0;
            rd_q <= rd_o;
            if (rd_q)
                shreg <= rdata_i;

            // SIOD only moves HOLD_CYC cycles after a fall; the level is chosen then
            if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
                if (hold_cnt == HW'(1)) begin
                    case (state)
                        ST_ACK_W: drive_low <= 1'b1;
                        ST_RDATA: drive_low <= ~shreg[7];
                        default:  drive_low <= 1'b0;
                    endcase
                end
            end

            if (stop_det) begin
                state     <= ST_IDLE;
                busy_o    <= 1'b0;
                drive_low <= 1'b0;
                hold_cnt  <= '0;
            end else if (start_det) begin
                state     <= ST_ID;
                bit_cnt   <= '0;
                busy_o    <= 1'b1;
                drive_low <= 1'b0;
                hold_cnt  <= '0;
            end else begin
                if (scl_fall && state != ST_IDLE)
                    hold_cnt <= HW'(HOLD_CYC);

                case (state)
                    ST_ID, ST_SUB, ST_WDATA: begin
                        if (scl_rise && bit_cnt < 4'd8) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                case (state)
                                    ST_ID: begin
                                        if (!sccb_id_match(rx_byte, DEV_ID))
                                            state <= ST_IGNORE;
                                        else
                                            ack_next <= rx_byte[0] ? ST_RDATA : ST_SUB;
                                    end
                                    ST_SUB: begin
                                        addr_o   <= rx_byte;
                                        ack_next <= ST_WDATA;
                                        first_wr <= 1'b1;
                                    end
                                    default: begin
                                        wr_o     <= 1'b1;
                                        wdata_o  <= rx_byte;
                                        first_wr <= 1'b0;
                                        ack_next <= ST_WDATA;
                                        if (!first_wr)
                                            addr_o <= addr_o + 8'd1;
                                    end
                                endcase
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state   <= ST_ACK_W;
                            bit_cnt <= '0;
                        end
                    end

                    ST_ACK_W: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= ack_next;
                            bit_cnt <= '0;
                            if (ack_next == ST_RDATA)
                                rd_o <= 1'b1;
                        end
                    end

                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state   <= ST_ACK_R;
                                bit_cnt <= '0;
                            end else if (bit_cnt != 4'd0) begin
                                shreg <= {shreg[6:0], 1'b0};
                            end
                        end
                    end

                    ST_ACK_R: begin
                        if (scl_rise) begin
                            if (sda == SCCB_NA)
                                state <= ST_IGNORE;
                            else
                                bit_cnt <= 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            addr_o  <= addr_o + 8'd1;
                            rd_o    <= 1'b1;
                            state   <= ST_RDATA;
                            bit_cnt <= '0;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench: bit-banged SCCB master, register-store model and a
// scoreboard of expected write/read strobes.
module tb_sccb_responder;

    localparam int QTR = 2500;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       sioc_i = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] rdata_i = 8'h00;
    logic [7:0] addr_o, wdata_o;
    logic       wr_o, rd_o, busy_o;
    wire        siod_io;

    assign siod_io = m_sda_low ? 1'b0 : 1'bz;
    pullup (siod_io);

    sccb_responder #(.DEV_ID(8'h42), .HOLD_CYC(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sioc_i  (sioc_i),
        .siod_io (siod_io),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .wr_o    (wr_o),
        .rd_o    (rd_o),
        .rdata_i (rdata_i),
        .busy_o  (busy_o)
    );

    always #21 clk_i = ~clk_i;

    logic [7:0]  mem [256];
    always @(posedge clk_i) if (rd_o) rdata_i <= mem[addr_o];

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int low_cnt = 0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [15:0] ew;
    logic [7:0]  er;

    task automatic m_bit(input logic b, output logic s);
        m_sda_low = ~b;
        #QTR sioc_i = 1'b1;
        #QTR s = siod_io;
        #QTR sioc_i = 1'b0;
        #QTR;
    endtask

    task automatic m_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(d[i], s);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read(input logic na, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, s);
            d = {d[6:0], s};
        end
        m_bit(na, s);
    endtask

    task automatic m_start();
        m_sda_low = 1'b0;
        #QTR sioc_i = 1'b1;
        #QTR m_sda_low = 1'b1;
        #QTR sioc_i = 1'b0;
        #QTR;
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1;
        #QTR sioc_i = 1'b1;
        #QTR m_sda_low = 1'b0;
        #QTR;
    endtask

    task automatic test_reset();
        #100;
        total++; if (siod_io !== 1'b1) begin bad++; $display("FAIL reset_siod got %b expected 1", siod_io); end
        total++; if (addr_o !== 8'h00) begin bad++; $display("FAIL reset_addr got %h expected 00", addr_o); end
        total++; if (wdata_o !== 8'h00) begin bad++; $display("FAIL reset_wdata got %h expected 00", wdata_o); end
        total++; if ({wr_o, rd_o, busy_o} !== 3'b000) begin bad++; $display("FAIL reset_strobes got %b expected 000", {wr_o, rd_o, busy_o}); end
        rst_i = 1'b1;
        repeat (10) @(negedge clk_i);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        int w0 = wr_cnt;
        m_start();
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL write_busy got %b expected 1", busy_o); end
        m_byte(8'h42, a0);
        m_byte(8'h12, a1);
        exp_wr.push_back({8'h12, 8'h80});
        m_byte(8'h80, a2);
        m_stop();
        repeat (20) @(negedge clk_i);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL write_acks got %b expected 000", {a0, a1, a2}); end
        total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL write_count got %0d expected 1", wr_cnt - w0); end
        total++; if (exp_wr.size() !== 0) begin bad++; $display("FAIL write_pending got %0d expected 0", exp_wr.size()); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL write_busy_stop got %b expected 0", busy_o); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d;
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        m_start();
        m_byte(8'h42, a0);
        m_byte(8'h0A, a1);
        m_stop();
        m_start();
        exp_rd.push_back(8'h0A);
        m_byte(8'h43, a2);
        m_read(1'b1, d);
        total++; if (siod_io !== 1'b1) begin bad++; $display("FAIL read_release got %b expected 1", siod_io); end
        m_stop();
        repeat (20) @(negedge clk_i);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL read_acks got %b expected 000", {a0, a1, a2}); end
        total++; if (d !== 8'h76) begin bad++; $display("FAIL read_data got %h expected 76", d); end
        total++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin bad++; $display("FAIL read_counts got rd=%0d wr=%0d expected rd=1 wr=0", rd_cnt - r0, wr_cnt - w0); end
        total++; if (exp_rd.size() !== 0) begin bad++; $display("FAIL read_pending got %0d expected 0", exp_rd.size()); end
    endtask

    task automatic test_reset_mid_ack();
        logic s, a0, a1, a2;
        logic [7:0] id = 8'h42;
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(id[i], s);
        m_sda_low = 1'b0;
        #QTR;
        total++; if (siod_io !== 1'b0) begin bad++; $display("FAIL rst_ack_driven got %b expected 0", siod_io); end
        #(QTR/2) rst_i = 1'b0;
        #1;
        total++; if (siod_io !== 1'b1) begin bad++; $display("FAIL rst_siod got %b expected 1", siod_io); end
        total++; if ({addr_o, wdata_o} !== 16'h0000 || {wr_o, rd_o, busy_o} !== 3'b000) begin bad++; $display("FAIL rst_outputs got addr=%h wdata=%h wr/rd/busy=%b expected 00 00 000", addr_o, wdata_o, {wr_o, rd_o, busy_o}); end
        #200 rst_i = 1'b1;
        sioc_i = 1'b1;
        #(2*QTR) sioc_i = 1'b0;
        #QTR;
        m_stop();
        m_start();
        m_byte(8'h42, a0);
        m_byte(8'h5C, a1);
        exp_wr.push_back({8'h5C, 8'hA7});
        m_byte(8'hA7, a2);
        m_stop();
        repeat (20) @(negedge clk_i);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rst_next_acks got %b expected 000", {a0, a1, a2}); end
        total++; if (exp_wr.size() !== 0) begin bad++; $display("FAIL rst_next_pending got %0d expected 0", exp_wr.size()); end
    endtask

    task automatic test_foreign_id();
        logic a0, a1;
        int w0 = wr_cnt;
        int r0 = rd_cnt;
        int l0 = low_cnt;
        m_start();
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL foreign_busy got %b expected 1", busy_o); end
        m_byte(8'h60, a0);
        m_byte(8'h12, a1);
        m_stop();
        repeat (20) @(negedge clk_i);
        total++; if ({a0, a1} !== 2'b11) begin bad++; $display("FAIL foreign_acks got %b expected 11", {a0, a1}); end
        total++; if (low_cnt - l0 !== 0) begin bad++; $display("FAIL foreign_drive got %0d low cycles expected 0", low_cnt - l0); end
        total++; if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0) begin bad++; $display("FAIL foreign_strobes got wr=%0d rd=%0d expected 0 0", wr_cnt - w0, rd_cnt - r0); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL foreign_busy_stop got %b expected 0", busy_o); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2, a3;
        int w0 = wr_cnt;
        m_start();
        m_byte(8'h42, a0);
        m_byte(8'hFF, a1);
        exp_wr.push_back({8'hFF, 8'h11});
        m_byte(8'h11, a2);
        exp_wr.push_back({8'h00, 8'h22});
        m_byte(8'h22, a3);
        m_stop();
        repeat (20) @(negedge clk_i);
        total++; if ({a0, a1, a2, a3} !== 4'b0000) begin bad++; $display("FAIL wrap_acks got %b expected 0000", {a0, a1, a2, a3}); end
        total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL wrap_count got %0d expected 2", wr_cnt - w0); end
        total++; if (exp_wr.size() !== 0) begin bad++; $display("FAIL wrap_pending got %0d expected 0", exp_wr.size()); end
    endtask

    task automatic test_abort_restart();
        logic s, a0, a1, a2;
        logic [7:0] d;
        logic [7:0] dat = 8'hA5;
        int w0 = wr_cnt;
        m_start();
        m_byte(8'h42, a0);
        m_byte(8'h33, a1);
        for (int i = 7; i >= 4; i--) m_bit(dat[i], s);
        m_start();
        exp_rd.push_back(8'h33);
        m_byte(8'h43, a2);
        m_read(1'b1, d);
        m_stop();
        repeat (20) @(negedge clk_i);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL abort_acks got %b expected 000", {a0, a1, a2}); end
        total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL abort_write got %0d strobes expected 0", wr_cnt - w0); end
        total++; if (d !== mem[8'h33]) begin bad++; $display("FAIL abort_read got %h expected %h", d, mem[8'h33]); end
        total++; if (exp_rd.size() !== 0) begin bad++; $display("FAIL abort_pending got %0d expected 0", exp_rd.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h0A] = 8'h76;
        fork
            forever begin
                @(negedge clk_i);
                if (!m_sda_low && siod_io === 1'b0) low_cnt++;
                if (wr_o) begin
                    wr_cnt++;
                    total++;
                    if (exp_wr.size() == 0) begin
                        bad++;
                        $display("FAIL wr_unexpected got addr=%h data=%h expected none", addr_o, wdata_o);
                    end else begin
                        ew = exp_wr.pop_front();
                        if ({addr_o, wdata_o} !== ew) begin
                            bad++;
                            $display("FAIL wr_strobe got addr=%h data=%h expected addr=%h data=%h", addr_o, wdata_o, ew[15:8], ew[7:0]);
                        end
                    end
                end
                if (rd_o) begin
                    rd_cnt++;
                    total++;
                    if (exp_rd.size() == 0) begin
                        bad++;
                        $display("FAIL rd_unexpected got addr=%h expected none", addr_o);
                    end else begin
                        er = exp_rd.pop_front();
                        if (addr_o !== er) begin
                            bad++;
                            $display("FAIL rd_strobe got addr=%h expected addr=%h", addr_o, er);
                        end
                    end
                end
            end
            begin
                test_reset();
                test_write();
                test_read();
                test_reset_mid_ack();
                test_foreign_id();
                test_wrap();
                test_abort_restart();
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
